// File: rtl/conv_load_sched_if.sv
// ---------------------------------------------------------------------------
// conv_load_sched_if
// Bundles the load scheduler's input stream (valid/ready) and its shared,
// registered per-tile write bus (kernel BRAM 1/2, input URAM, tile index,
// broadcast flag and kernel-load pulse).
//   master : the side that supplies stream words and consumes the write bus
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface conv_load_sched_if #(
   parameter int Y        = 480,
   parameter int A_W      = 14,
   parameter int M_W      = 18,
   parameter int URAM_A_W = 23,
   parameter int URAM_D_W = 72
);
   localparam int TILE_W = (Y > 1) ? $clog2(Y) : 1;

   // input stream
   logic [URAM_D_W-1:0] s_data;
   logic                s_valid;
   logic                s_ready;

   // shared write bus
   logic [TILE_W-1:0]   wr_tile;
   logic                wr_bcast;
   logic [A_W-1:0]      krnl_bram1_wraddr;
   logic [M_W-1:0]      krnl_bram1_wrdata;
   logic                krnl_bram1_wren;
   logic [A_W-1:0]      krnl_bram2_wraddr;
   logic [M_W-1:0]      krnl_bram2_wrdata;
   logic                krnl_bram2_wren;
   logic [URAM_A_W-1:0] uram1_wr_addr;
   logic [URAM_D_W-1:0] uram1_wr_data;
   logic                uram1_wr_en;
   logic                ld_new_kernel;

   modport master (
      output s_data, s_valid,
      input  s_ready,
      input  wr_tile, wr_bcast,
      input  krnl_bram1_wraddr, krnl_bram1_wrdata, krnl_bram1_wren,
      input  krnl_bram2_wraddr, krnl_bram2_wrdata, krnl_bram2_wren,
      input  uram1_wr_addr, uram1_wr_data, uram1_wr_en,
      input  ld_new_kernel
   );

   modport slave (
      input  s_data, s_valid,
      output s_ready,
      output wr_tile, wr_bcast,
      output krnl_bram1_wraddr, krnl_bram1_wrdata, krnl_bram1_wren,
      output krnl_bram2_wraddr, krnl_bram2_wrdata, krnl_bram2_wren,
      output uram1_wr_addr, uram1_wr_data, uram1_wr_en,
      output ld_new_kernel
   );
endinterface

// File: rtl/conv_load_sched.sv
// ---------------------------------------------------------------------------
// conv_load_sched
// Sequences one valid/ready stream into every tile's kernel BRAM 1, kernel
// BRAM 2 and input URAM, in that order, tile by tile. All write-bus outputs,
// busy and done are registered; s_ready is a decode of the state register.
//
// Optional feature (macro CONV_LOAD_BCAST_EN):
//   defined   - kernels are loaded once and broadcast to all tiles
//               (wr_bcast = 1, wr_tile = 0), then the image phase walks the
//               tiles back to back without revisiting the kernel states.
//   undefined - per-tile kernels; wr_bcast is tied low.
// ---------------------------------------------------------------------------
module conv_load_sched #(
   parameter int Y        = 480,
   parameter int KERN_SZ  = 3,
   parameter int IMG_W    = 4,
   parameter int IMG_D    = 6,
   parameter int A_W      = 14,
   parameter int M_W      = 18,
   parameter int URAM_A_W = 23,
   parameter int URAM_D_W = 72
) (
   input  logic             clk,
   input  logic             rst,     // asynchronous, active low
   input  logic             start,
   input  logic             abort,
   conv_load_sched_if.slave bus,
   output logic             busy,
   output logic             done
);

   localparam int KN      = KERN_SZ * KERN_SZ;
   localparam int IMG_N   = IMG_W * IMG_D;
   localparam int TILE_W  = (Y > 1) ? $clog2(Y) : 1;
   localparam int CNT_MAX = (KN > IMG_N) ? KN : IMG_N;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]  KN_LAST   = CNT_W'(KN - 1);
   localparam logic [CNT_W-1:0]  IMG_LAST  = CNT_W'(IMG_N - 1);
   localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(Y - 1);

`ifdef CONV_LOAD_BCAST_EN
   localparam logic BCAST = 1'b1;
`else
   localparam logic BCAST = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_K1   = 3'd1,
      ST_K2   = 3'd2,
      ST_IMG  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t              state_r, state_s;
   logic [TILE_W-1:0]   tile_r, tile_s;
   logic [CNT_W-1:0]    wcnt_r, wcnt_s;
   logic [CNT_W-1:0]    wcnt_inc_s;
   logic                ready_s;
   logic                beat_s;
   logic                kern_s;

   logic [TILE_W-1:0]   wr_tile_r;
   logic                wr_bcast_r;
   logic [A_W-1:0]      b1_addr_r;
   logic [M_W-1:0]      b1_data_r;
   logic                b1_en_r;
   logic [A_W-1:0]      b2_addr_r;
   logic [M_W-1:0]      b2_data_r;
   logic                b2_en_r;
   logic [URAM_A_W-1:0] u_addr_r;
   logic [URAM_D_W-1:0] u_data_r;
   logic                u_en_r;
   logic                ld_r;
   logic                busy_r;
   logic                done_r;

   // Ready decode: the three loading states accept words, nothing else does
   always_comb begin
      ready_s = 1'b0;
      case (state_r)
         ST_K1, ST_K2, ST_IMG: ready_s = 1'b1;
         default:              ready_s = 1'b0;
      endcase
   end

   // abort wins over a same-cycle beat, so it also blocks acceptance
   assign beat_s     = bus.s_valid && ready_s && !abort;
   assign kern_s     = (state_r == ST_K1) || (state_r == ST_K2);
   assign wcnt_inc_s = wcnt_r + CNT_W'(1);

   // Next-state, tile and word-counter logic
   always_comb begin
      state_s = state_r;
      tile_s  = tile_r;
      wcnt_s  = wcnt_r;
      if (abort) begin
         state_s = ST_IDLE;
         tile_s  = '0;
         wcnt_s  = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_s = ST_K1;
                  tile_s  = '0;
                  wcnt_s  = '0;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_K1: begin
               if (beat_s && (wcnt_r == KN_LAST)) begin
                  state_s = ST_K2;
                  wcnt_s  = '0;
               end else if (beat_s) begin
                  wcnt_s = wcnt_inc_s;
               end else begin
                  wcnt_s = wcnt_r;
               end
            end
            ST_K2: begin
               if (beat_s && (wcnt_r == KN_LAST)) begin
                  state_s = ST_IMG;
                  wcnt_s  = '0;
               end else if (beat_s) begin
                  wcnt_s = wcnt_inc_s;
               end else begin
                  wcnt_s = wcnt_r;
               end
            end
            ST_IMG: begin
               if (beat_s && (wcnt_r == IMG_LAST) && (tile_r == TILE_LAST)) begin
                  state_s = ST_DONE;
                  wcnt_s  = '0;
               end else if (beat_s && (wcnt_r == IMG_LAST)) begin
                  // broadcast kernels are already resident in every tile
                  state_s = BCAST ? ST_IMG : ST_K1;
                  tile_s  = tile_r + TILE_W'(1);
                  wcnt_s  = '0;
               end else if (beat_s) begin
                  wcnt_s = wcnt_inc_s;
               end else begin
                  wcnt_s = wcnt_r;
               end
            end
            ST_DONE: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s = ST_IDLE;
               tile_s  = '0;
               wcnt_s  = '0;
            end
         endcase
      end
   end

   // State, tile and word-counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         tile_r  <= '0;
         wcnt_r  <= '0;
      end else begin
         state_r <= state_s;
         tile_r  <= tile_s;
         wcnt_r  <= wcnt_s;
      end
   end

   // Registered write bus: a strobe and its qualifiers follow the accepting edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_tile_r  <= '0;
         wr_bcast_r <= 1'b0;
         b1_addr_r  <= '0;
         b1_data_r  <= '0;
         b1_en_r    <= 1'b0;
         b2_addr_r  <= '0;
         b2_data_r  <= '0;
         b2_en_r    <= 1'b0;
         u_addr_r   <= '0;
         u_data_r   <= '0;
         u_en_r     <= 1'b0;
         ld_r       <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         b1_en_r <= beat_s && (state_r == ST_K1);
         b2_en_r <= beat_s && (state_r == ST_K2);
         u_en_r  <= beat_s && (state_r == ST_IMG);
         // weights are resident once the last bram2 word lands
         ld_r    <= beat_s && (state_r == ST_K2) && (wcnt_r == KN_LAST);
         done_r  <= (state_r == ST_DONE);
         busy_r  <= (state_s != ST_IDLE);
         if (beat_s) begin
            wr_tile_r  <= (BCAST && kern_s) ? '0 : tile_r;
            wr_bcast_r <= BCAST && kern_s;
         end else begin
            wr_tile_r  <= wr_tile_r;
            wr_bcast_r <= wr_bcast_r;
         end
         if (beat_s && (state_r == ST_K1)) begin
            b1_addr_r <= A_W'(wcnt_r);
            b1_data_r <= bus.s_data[M_W-1:0];
         end else begin
            b1_addr_r <= b1_addr_r;
            b1_data_r <= b1_data_r;
         end
         if (beat_s && (state_r == ST_K2)) begin
            b2_addr_r <= A_W'(wcnt_r);
            b2_data_r <= bus.s_data[M_W-1:0];
         end else begin
            b2_addr_r <= b2_addr_r;
            b2_data_r <= b2_data_r;
         end
         if (beat_s && (state_r == ST_IMG)) begin
            u_addr_r <= URAM_A_W'(wcnt_r);
            u_data_r <= bus.s_data;
         end else begin
            u_addr_r <= u_addr_r;
            u_data_r <= u_data_r;
         end
      end
   end

   assign bus.s_ready           = ready_s;
   assign bus.wr_tile           = wr_tile_r;
   assign bus.wr_bcast          = wr_bcast_r;
   assign bus.krnl_bram1_wraddr = b1_addr_r;
   assign bus.krnl_bram1_wrdata = b1_data_r;
   assign bus.krnl_bram1_wren   = b1_en_r;
   assign bus.krnl_bram2_wraddr = b2_addr_r;
   assign bus.krnl_bram2_wrdata = b2_data_r;
   assign bus.krnl_bram2_wren   = b2_en_r;
   assign bus.uram1_wr_addr     = u_addr_r;
   assign bus.uram1_wr_data     = u_data_r;
   assign bus.uram1_wr_en       = u_en_r;
   assign bus.ld_new_kernel     = ld_r;
   assign busy                  = busy_r;
   assign done                  = done_r;

endmodule

// File: tb/tb_conv_load_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_load_sched
// Directed bench for conv_load_sched with Y = 2 (KN = 9, IMG_N = 24).
// Expected write-bus contents are computed from the global beat index.
// ---------------------------------------------------------------------------
module tb_conv_load_sched;

   localparam int Y        = 2;
   localparam int A_W      = 14;
   localparam int M_W      = 18;
   localparam int URAM_A_W = 23;
   localparam int URAM_D_W = 72;
`ifdef CONV_LOAD_BCAST_EN
   localparam int TOTAL = 66;
`else
   localparam int TOTAL = 84;
`endif

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic abort;
   logic busy;
   logic done;
   int   checks = 0;
   int   errors = 0;

   conv_load_sched_if #(.Y(Y), .A_W(A_W), .M_W(M_W), .URAM_A_W(URAM_A_W),
                        .URAM_D_W(URAM_D_W)) bus ();

   conv_load_sched #(.Y(Y)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .abort (abort),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // one comparison: count it, report a mismatch
   task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] pack(
      input logic e1, input logic [A_W-1:0] a1, input logic [M_W-1:0] d1,
      input logic e2, input logic [A_W-1:0] a2, input logic [M_W-1:0] d2,
      input logic eu, input logic [URAM_A_W-1:0] au, input logic [URAM_D_W-1:0] du,
      input logic t, input logic bc, input logic ld, input logic by, input logic dn);
      return 256'({e1, a1, d1, e2, a2, d2, eu, au, du, t, bc, ld, by, dn});
   endfunction

   // only busy/done may be set, no strobe
   function automatic logic [255:0] idle_sig(input logic by, input logic dn);
      return pack(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, by, dn);
   endfunction

   // observed bus with addr/data/tile of non-strobing ports masked out
   function automatic logic [255:0] obs_sig();
      logic any;
      any = bus.krnl_bram1_wren | bus.krnl_bram2_wren | bus.uram1_wr_en;
      return pack(bus.krnl_bram1_wren,
                  bus.krnl_bram1_wren ? bus.krnl_bram1_wraddr : '0,
                  bus.krnl_bram1_wren ? bus.krnl_bram1_wrdata : '0,
                  bus.krnl_bram2_wren,
                  bus.krnl_bram2_wren ? bus.krnl_bram2_wraddr : '0,
                  bus.krnl_bram2_wren ? bus.krnl_bram2_wrdata : '0,
                  bus.uram1_wr_en,
                  bus.uram1_wr_en ? bus.uram1_wr_addr : '0,
                  bus.uram1_wr_en ? bus.uram1_wr_data : '0,
                  any ? bus.wr_tile[0] : 1'b0,
                  any ? bus.wr_bcast : 1'b0,
                  bus.ld_new_kernel, busy, done);
   endfunction

   // every output exactly as driven
   function automatic logic [255:0] raw_sig();
      return pack(bus.krnl_bram1_wren, bus.krnl_bram1_wraddr, bus.krnl_bram1_wrdata,
                  bus.krnl_bram2_wren, bus.krnl_bram2_wraddr, bus.krnl_bram2_wrdata,
                  bus.uram1_wr_en, bus.uram1_wr_addr, bus.uram1_wr_data,
                  bus.wr_tile[0], bus.wr_bcast, bus.ld_new_kernel, busy, done);
   endfunction

   // expected strobe for global beat index b
   function automatic logic [255:0] exp_sig(input int b, input logic [7:0] upper);
      int   k;
      int   a;
      int   t;
      int   r;
      logic bc;
      logic ld;
      logic [URAM_D_W-1:0] d;
      d = {upper, 64'(b)};
`ifdef CONV_LOAD_BCAST_EN
      r  = b;
      bc = (b < 18);
      t  = (b < 18) ? 0 : (b - 18) / 24;
      if (b < 9) begin
         k = 1; a = b;
      end else if (b < 18) begin
         k = 2; a = b - 9;
      end else begin
         k = 3; a = (b - 18) % 24;
      end
`else
      t  = b / 42;
      r  = b % 42;
      bc = 1'b0;
      if (r < 9) begin
         k = 1; a = r;
      end else if (r < 18) begin
         k = 2; a = r - 9;
      end else begin
         k = 3; a = r - 18;
      end
`endif
      ld = (k == 2) && (a == 8);
      return pack(k == 1, (k == 1) ? A_W'(a) : '0, (k == 1) ? M_W'(b) : '0,
                  k == 2, (k == 2) ? A_W'(a) : '0, (k == 2) ? M_W'(b) : '0,
                  k == 3, (k == 3) ? URAM_A_W'(a) : '0, (k == 3) ? d : '0,
                  t[0], bc, ld, 1'b1, 1'b0);
   endfunction

   // start a sequence and stream it; optional abort or reset at a given beat
   task automatic run_stream(input bit toggle, input int abort_at, input int rst_at,
                             input bit hold_start, input logic [7:0] upper);
      int b;
      int cyc;
      bit v;
      bit acc;
      bit ended;
      b     = 0;
      cyc   = 0;
      ended = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("start", obs_sig(), idle_sig(1'b1, 1'b0));
      while (!ended && (b < TOTAL) && (cyc < 1000)) begin
         v            = toggle ? (cyc % 2 == 0) : 1'b1;
         bus.s_valid  = v;
         bus.s_data   = {upper, 64'(b)};
         start        = hold_start && (b >= 18) && (b < 42);
         abort        = v && (b == abort_at);
         check_val("s_ready", 256'(bus.s_ready), 256'(1'b1));
         if (v && (b == rst_at)) begin
            #2;
            rst = 1'b0;
            #1;
            check_val("rst_async", raw_sig(), '0);
            check_val("rst_ready", 256'(bus.s_ready), '0);
            ended = 1'b1;
         end else begin
            acc = v && !abort;
            tick();
            if (acc) begin
               check_val("strobe", obs_sig(), exp_sig(b, upper));
               b++;
            end else if (abort) begin
               check_val("abort", obs_sig(), idle_sig(1'b0, 1'b0));
               check_val("abort_ready", 256'(bus.s_ready), '0);
               ended = 1'b1;
            end else begin
               check_val("bubble", obs_sig(), idle_sig(1'b1, 1'b0));
            end
            abort = 1'b0;
            cyc++;
         end
      end
      bus.s_valid = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      if (!ended) begin
         tick();
         check_val("done", obs_sig(), idle_sig(1'b0, 1'b1));
         tick();
         check_val("after_done", obs_sig(), idle_sig(1'b0, 1'b0));
      end
   endtask

   initial begin
      rst         = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      tick();
      tick();
      check_val("reset", raw_sig(), '0);
      check_val("reset_ready", 256'(bus.s_ready), '0);
      rst = 1'b1;
      tick();
      check_val("idle", raw_sig(), '0);

      // continuous stream
      run_stream(1'b0, -1, -1, 1'b0, 8'h00);
      // half-rate stream, upper data bits set
      run_stream(1'b1, -1, -1, 1'b0, 8'hA5);

      // abort at beat 30, no done afterwards, then a clean restart
      run_stream(1'b0, 30, -1, 1'b0, 8'h00);
      tick();
      check_val("abort_no_done1", obs_sig(), idle_sig(1'b0, 1'b0));
      tick();
      check_val("abort_no_done2", obs_sig(), idle_sig(1'b0, 1'b0));
      run_stream(1'b0, -1, -1, 1'b0, 8'h00);

      // reset mid tile-1 K2, then no activity until start
      run_stream(1'b0, -1, 55, 1'b0, 8'h00);
      bus.s_valid = 1'b1;
      tick();
      check_val("in_rst", raw_sig(), '0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("post_rst", raw_sig(), '0);
         check_val("post_rst_ready", 256'(bus.s_ready), '0);
      end
      bus.s_valid = 1'b0;

      // start held high during image phase has no effect
      run_stream(1'b0, -1, -1, 1'b1, 8'h00);

      // start together with abort in idle stays idle
      start = 1'b1;
      abort = 1'b1;
      tick();
      check_val("start_abort", obs_sig(), idle_sig(1'b0, 1'b0));
      check_val("start_abort_ready", 256'(bus.s_ready), '0);
      start = 1'b0;
      abort = 1'b0;
      tick();
      check_val("start_abort_idle", obs_sig(), idle_sig(1'b0, 1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
